// File: rtl/seg_adder_pkg.sv
// Shared types and helpers for the segmented carry adder.
// Holds the control state encoding and the segment count function.
package seg_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic int nseg(
    input int width,
    input int seg_w
  );
    return (width + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/seg_add_slice.sv
// Combinational W-bit adder slice with carry in/out.
// One instance is time-shared across all segments.
module seg_add_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = a_i + b_i + {{(W-1){1'b0}}, cin_i};

endmodule

// File: rtl/seg_carry_adder.sv
// Multi-cycle adder: one SEG_W segment per clock, registered carry.
// Define SEG_CARRY_ADDER_SUB_EN to add the sub_i (a-b) input.
module seg_carry_adder
  import seg_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SEG_CARRY_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NSEG   = nseg(WIDTH, SEG_W);
  localparam int LAST_W = WIDTH - (NSEG - 1) * SEG_W;
  localparam int CNT_W  = $clog2(NSEG + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SEG_W-1:0]   a_seg, b_seg, sum;
  logic               slice_cout;
  logic [SEG_W:0]     full;
  logic               last_seg;
  logic               seg_carry;

  // Pick the operand bits of the active segment; pad short tail with 0
  always_comb begin
    a_seg = '0;
    b_seg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i / SEG_W == int'(seg_cnt_q)) begin
        a_seg[i % SEG_W] = a_q[i];
        b_seg[i % SEG_W] = b_q[i];
      end
    end
  end

  seg_add_slice #(
    .W(SEG_W)
  ) u_slice (
    .a_i   (a_seg),
    .b_i   (b_seg),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(slice_cout)
  );

  assign full     = {slice_cout, sum};
  assign last_seg = (seg_cnt_q == CNT_W'(NSEG - 1));
  // Zero-padded tail: its carry lands at bit LAST_W of the slice sum
  assign seg_carry = last_seg ? full[LAST_W] : full[SEG_W];

  // Next-state, operand capture and per-segment result update
  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d       = a_i;
`ifdef SEG_CARRY_ADDER_SUB_EN
          b_d       = sub_i ? ~b_i : b_i;
          carry_d   = sub_i ? 1'b1 : cin_i;
`else
          b_d       = b_i;
          carry_d   = cin_i;
`endif
          seg_cnt_d = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i / SEG_W == int'(seg_cnt_q)) begin
            res_d[i] = sum[i % SEG_W];
          end
        end
        carry_d   = seg_carry;
        seg_cnt_d = seg_cnt_q + CNT_W'(1);
        if (last_seg) begin
          cout_d  = seg_carry;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (sum[LAST_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      seg_cnt_q <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign res_o   = res_q;
  assign cout_o  = cout_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_seg_carry_adder.sv
// Directed bench for seg_carry_adder at W32/S16 and W20/S8.
// Sub-mode vectors run when SEG_CARRY_ADDER_SUB_EN is defined.
module tb_seg_carry_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        v_i32, r_o32, cin32, v_o32, rdy32, cout32, ovf32, sub32;
  logic [31:0] a32, b32, res32;
  logic        v_i20, r_o20, cin20, v_o20, rdy20, cout20, ovf20, sub20;
  logic [19:0] a20, b20, res20;

  int compared = 0;
  int fails    = 0;

  seg_carry_adder #(.WIDTH(32), .SEG_W(16)) u32 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(v_i32),
    .ready_o(r_o32),
    .a_i    (a32),
    .b_i    (b32),
    .cin_i  (cin32),
`ifdef SEG_CARRY_ADDER_SUB_EN
    .sub_i  (sub32),
`endif
    .valid_o(v_o32),
    .ready_i(rdy32),
    .res_o  (res32),
    .cout_o (cout32),
    .ovf_o  (ovf32)
  );

  seg_carry_adder #(.WIDTH(20), .SEG_W(8)) u20 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(v_i20),
    .ready_o(r_o20),
    .a_i    (a20),
    .b_i    (b20),
    .cin_i  (cin20),
`ifdef SEG_CARRY_ADDER_SUB_EN
    .sub_i  (sub20),
`endif
    .valid_o(v_o20),
    .ready_i(rdy20),
    .res_o  (res20),
    .cout_o (cout20),
    .ovf_o  (ovf20)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_vo(input bit w20);
    return w20 ? v_o20 : v_o32;
  endfunction

  function automatic logic get_ro(input bit w20);
    return w20 ? r_o20 : r_o32;
  endfunction

  function automatic logic [31:0] get_res(input bit w20);
    return w20 ? {12'h000, res20} : res32;
  endfunction

  // Accept one op, measure latency, check result flags.
  // Returns to IDLE afterwards only if ready_i is high.
  task automatic run_op(input bit w20, input string tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub,
                        input logic [31:0] er, input logic ec,
                        input logic eo, input int elat);
    int n;
    if (w20) begin
      a20 = a[19:0]; b20 = b[19:0]; cin20 = cin; sub20 = sub;
      v_i20 = 1'b1;
    end else begin
      a32 = a; b32 = b; cin32 = cin; sub32 = sub;
      v_i32 = 1'b1;
    end
    @(posedge clk); #1;
    v_i20 = 1'b0;
    v_i32 = 1'b0;
    check({tag, "_busy"}, {31'b0, get_ro(w20)}, 32'd0);
    n = 0;
    while (!get_vo(w20) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_res"}, get_res(w20), er);
    check({tag, "_cout"}, {31'b0, w20 ? cout20 : cout32}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, w20 ? ovf20 : ovf32}, {31'b0, eo});
    if ((w20 ? rdy20 : rdy32) == 1'b1) begin
      @(posedge clk); #1;
      check({tag, "_drop"}, {31'b0, get_vo(w20)}, 32'd0);
      check({tag, "_rdy"}, {31'b0, get_ro(w20)}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v_i32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; rdy32 = 1;
    v_i20 = 0; a20 = 0; b20 = 0; cin20 = 0; sub20 = 0; rdy20 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready32", {31'b0, r_o32}, 32'd1);
    check("rst_valid32", {31'b0, v_o32}, 32'd0);
    check("rst_res32", res32, 32'd0);
    check("rst_flags32", {30'b0, cout32, ovf32}, 32'd0);
    check("rst_ready20", {31'b0, r_o20}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, "w32_carry16", 32'h0000FFFF, 32'h1, 0, 0,
           32'h00010000, 0, 0, 2);
    run_op(0, "w32_wrap", 32'hFFFFFFFF, 32'h1, 0, 0,
           32'h0, 1, 0, 2);
    run_op(0, "w32_negovf", 32'h80000000, 32'h80000000, 0, 0,
           32'h0, 1, 1, 2);
    run_op(0, "w32_cin", 32'h7FFFFFFF, 32'h0, 1, 0,
           32'h80000000, 0, 1, 2);

    // Backpressure in DONE, with new operands offered meanwhile
    rdy32 = 1'b0;
    run_op(0, "bp", 32'h12345678, 32'h11111111, 0, 0,
           32'h23456789, 0, 0, 2);
    for (int k = 0; k < 5; k++) begin
      v_i32 = 1'b1;
      a32 = 32'hDEADBEEF;
      b32 = 32'h01010101;
      @(posedge clk); #1;
      check("bp_valid", {31'b0, v_o32}, 32'd1);
      check("bp_res", res32, 32'h23456789);
      check("bp_ready", {31'b0, r_o32}, 32'd0);
    end
    v_i32 = 1'b0;
    rdy32 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'b0, v_o32}, 32'd0);
    check("bp_release_ready", {31'b0, r_o32}, 32'd1);

    run_op(1, "w20_wrap", 32'hFFFFF, 32'h00001, 0, 0,
           32'h00000, 1, 0, 3);
    run_op(1, "w20_posovf", 32'h7FFFF, 32'h00001, 0, 0,
           32'h80000, 0, 1, 3);
    run_op(1, "w20_mix", 32'h12345, 32'h23456, 0, 0,
           32'h3579B, 0, 0, 3);

    // Reset one cycle into CALC drops the op
    a32 = 32'hFFFFFFFF;
    b32 = 32'hFFFFFFFF;
    v_i32 = 1'b1;
    @(posedge clk); #1;
    v_i32 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, r_o32}, 32'd1);
    check("midrst_valid", {31'b0, v_o32}, 32'd0);
    check("midrst_res", res32, 32'd0);
    check("midrst_flags", {30'b0, cout32, ovf32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, "post_rst", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 2);

`ifdef SEG_CARRY_ADDER_SUB_EN
    run_op(0, "sub_neg", 32'd5, 32'd7, 1, 1,
           32'hFFFFFFFE, 0, 0, 2);
    run_op(0, "sub_pos", 32'd7, 32'd5, 0, 1,
           32'd2, 1, 0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, fails);
    $finish;
  end

endmodule
